pattern_select_sequencer: RTL

Controller that sequences test-pattern selection for the 720p HDMI output path. It conditions the raw board switches and commits a new pattern select only on a frame boundary. It also emits a blanking request for a configurable number of frames after each change, so a sink never sees a torn frame. It sits between the board switches / video timing generator and the pattern generator's select and colour-mute inputs, all in the pixel clock domain.

---
 rtl/pattern_pkg.sv | 18 +
 rtl/switch_debouncer.sv | 40 ++++
 rtl/pattern_select_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// Shared types for the HDMI test-pattern select path: select width, pattern count, sequencer states.
package pattern_pkg;

    typedef logic [1:0] pattern_sel_t;

    localparam int NUM_PATTERNS = 4;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_BLANK      = 2'd2
    } seq_state_t;

    function automatic pattern_sel_t next_pattern(input pattern_sel_t sel);
        return pattern_sel_t'((32'(sel) + 1) % NUM_PATTERNS);
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus stability debouncer for a bank of raw switches.
// The output updates only after the synchronized value has held for DEBOUNCE_CYCLES.
module switch_debouncer #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             i_clk_pxl,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_sw,
    output logic [WIDTH-1:0] o_deb
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]      cand;
    logic [CW-1:0]         cnt;

    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            sync_q <= '0;
            cand   <= '0;
            cnt    <= '0;
            o_deb  <= '0;
        end else begin
            sync_q <= {sync_q[0], i_sw};
            if (sync_q[1] != cand) begin
                cand <= sync_q[1];
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            // cand is still the value that earned the full count, even if sync moves this cycle
            if (cnt == CNT_MAX)
                o_deb <= cand;
        end
    end

endmodule

// File: rtl/pattern_select_sequencer.sv
// Commits debounced pattern selects on frame boundaries and mutes colour for BLANK_FRAMES after each change.
// Optional auto-cycle stepping is compiled in with PATTERN_AUTOCYCLE_EN.
module pattern_select_sequencer
    import pattern_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BLANK_FRAMES    = 2
`ifdef PATTERN_AUTOCYCLE_EN
   ,parameter int AUTO_FRAMES     = 120
`endif
) (
    input  logic       i_clk_pxl,
    input  logic       i_reset,
    input  logic [1:0] i_sw,
    input  logic       i_nf,
`ifdef PATTERN_AUTOCYCLE_EN
    input  logic       i_auto,
`endif
    output logic [1:0] o_sel,
    output logic       o_blank,
    output logic       o_changed
);

    localparam int            BW         = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

    seq_state_t    state;
    pattern_sel_t  deb_sw;
    pattern_sel_t  target;
    logic [BW-1:0] blank_cnt;
    logic          auto_on;
    logic          frame_hit;
    logic          commit_en;

    switch_debouncer #(
        .WIDTH           (2),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .i_clk_pxl (i_clk_pxl),
        .i_reset   (i_reset),
        .i_sw      (i_sw),
        .o_deb     (deb_sw)
    );

`ifdef PATTERN_AUTOCYCLE_EN
    localparam int            FW       = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [FW-1:0] AUTO_HIT = FW'(AUTO_FRAMES - 1);

    logic [FW-1:0] frame_cnt;

    assign auto_on   = i_auto;
    assign frame_hit = (frame_cnt == AUTO_HIT);

    // Frames keep counting through blanking (saturating), so the step period is AUTO_FRAMES
    // frames commit-to-commit; the step itself only fires from S_RUN.
    always_ff @(posedge i_clk_pxl) begin
        if (i_reset || !i_auto)
            frame_cnt <= '0;
        else if (i_nf) begin
            if (commit_en)
                frame_cnt <= '0;
            else if (!frame_hit)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end
`else
    assign auto_on   = 1'b0;
    assign frame_hit = 1'b0;
`endif

    // target resolves to this cycle's deb_sw, so the latest stable switch value is what commits
    always_comb begin
        commit_en = 1'b0;
        target    = deb_sw;
        case (state)
            S_RUN: begin
                if (auto_on) begin
                    commit_en = i_nf && frame_hit;
                    target    = next_pattern(o_sel);
                end
            end
            S_WAIT_FRAME: commit_en = i_nf && !auto_on && (deb_sw != o_sel);
            default:      commit_en = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            state     <= S_RUN;
            o_sel     <= '0;
            o_blank   <= 1'b0;
            o_changed <= 1'b0;
            blank_cnt <= '0;
        end else begin
            o_changed <= 1'b0;
            if (commit_en) begin
                o_sel     <= target;
                o_changed <= 1'b1;
                if (BLANK_FRAMES > 0) begin
                    o_blank   <= 1'b1;
                    blank_cnt <= '0;
                    state     <= S_BLANK;
                end else begin
                    state <= S_RUN;
                end
            end else begin
                case (state)
                    S_RUN: begin
                        if (!auto_on && deb_sw != o_sel)
                            state <= S_WAIT_FRAME;
                    end
                    S_WAIT_FRAME: begin
                        if (auto_on || deb_sw == o_sel)
                            state <= S_RUN;
                    end
                    S_BLANK: begin
                        if (i_nf) begin
                            if (blank_cnt == BLANK_LAST) begin
                                o_blank <= 1'b0;
                                state   <= S_RUN;
                            end else begin
                                blank_cnt <= blank_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= S_RUN;
                endcase
            end
        end
    end

endmodule
